store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
MEM-stage store path for the pipelined CPU. It is the narrowing counterpart to sign_extend. Sign_extend widens a 16-bit immediate to 32 bits; this block narrows a 32-bit register value to byte, halfword or word lanes. It aligns the data into a little-endian 32-bit data-memory write bus and generates byte enables. Misaligned stores are split into two bus beats under a small FSM with a req/ack handshake, and the block holds off the pipeline until the store completes.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, data bus width; fixed at 32, 4 byte lanes.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
st_valid  in  1  MEM stage presents a store.
st_ready  out  1  block accepts the store this cycle.
st_addr  in  ADDR_W  byte address.
st_data  in  32  register data; low bytes are significant.
st_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
busy  out  1  a store is in flight; pipeline stall source.
done  out  1  one-cycle pulse when the last beat is acknowledged.
err  out  1  one-cycle pulse on a reserved st_size.
bus_req  out  1  write request.
bus_ack  in  1  memory accepts the current beat.
bus_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
bus_wdata  out  32  aligned write data.
bus_be  out  4  byte enables; bit i covers bus_wdata[8i+7:8i].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - bus_req=0, bus_addr=0, bus_wdata=0, bus_be=0.
  - busy=0, done=0, err=0.
  - st_ready=1 once reset is released.
  - A reset mid-transfer abandons the store immediately; there is no partial-beat recovery.
- st_ready = (state==IDLE). Acceptance = st_valid & st_ready at a clock edge.
- Alignment, combinational, at acceptance:
  - o = st_addr[1:0].
  - nbytes = 1, 2 or 4 by size.
  - data is masked to nbytes, then zero-extended to 64 bits: wide = masked_data << (8*o).
  - mask8 = ((1<<nbytes)-1) << o.
  - Beat0: be=mask8[3:0], wdata=wide[31:0], addr={st_addr[31:2],2'b00}.
  - Beat1: needed only if mask8[7:4]!=0. be=mask8[7:4], wdata=wide[63:32], addr=beat0 addr+4, modulo 2^ADDR_W. So 0xFFFFFFFC wraps to 0x00000000.
  - All beat fields are registered at acceptance. They are stable while bus_req=1.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE: valid size accepted -> BEAT0. bus_req=1 from the next cycle; busy=1.
  - IDLE: st_size=11 accepted -> err=1 for the next cycle. Stay in IDLE; no bus activity.
  - BEAT0: on bus_ack=1, go to BEAT1 if beat1 is needed. Otherwise go to IDLE with done=1 for one cycle.
  - BEAT1: outputs switch to the beat1 fields. On bus_ack=1, go to IDLE with done=1.
  - bus_ack while bus_req=0 is ignored.
- Latency with ack tied high:
  - Aligned store: accepted at edge N, beat on the bus during cycle N+1, done during cycle N+2.
  - Split store: done during cycle N+3.
- Ack and acceptance on the same edge is impossible, because st_ready=0 outside IDLE. Back-to-back stores are therefore spaced by at least one IDLE cycle.
- busy = (state!=IDLE). done and err are never asserted together.

Decomposition:
- Shared package store_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - FSM state encoding IDLE/BEAT0/BEAT1;
  - LANES=4.
- Sub-module: lane_align. Pure combinational: addr offset, size and data in; wide[63:0] and mask8[7:0] out. The top holds the FSM and registers only.

Test Plan:
1. Byte store, addr 0x00000013, data 0xAABBCCDD, ack tied 1 -> one beat: bus_addr 0x00000010, be 4'b1000, wdata 0xDD000000; done two cycles after acceptance.
2. Word store, addr 0x00000100, data 0x12345678 -> one beat: be 4'hF, wdata 0x12345678; exactly one bus_req cycle.
3. Misaligned half, addr 0x00000203, data 0x0000BEEF ->
   - beat0: addr 0x00000200, be 4'b1000, wdata 0xEF000000;
   - beat1: addr 0x00000204, be 4'b0001, wdata 0x000000BE;
   - one done pulse.
4. Misaligned word, addr 0xFFFFFFFE, data 0xCAFEF00D, ack delayed 3 cycles per beat ->
   - beat0: addr 0xFFFFFFFC, be 4'b1100, wdata 0xF00D0000;
   - beat1: addr 0x00000000 (wrap), be 4'b0011, wdata 0x0000CAFE;
   - beat fields held stable and busy=1 throughout.
5. st_size=11 -> err pulses one cycle; bus_req never rises; st_ready stays 1.
6. rst_n dropped during BEAT0 with ack=0 -> bus_req, busy and all outputs go to 0 asynchronously. After release, a new byte store completes normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the MEM-stage store path: access sizes, store FSM states
// and the byte-lane count of the data-memory write bus.
package store_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

endpackage

// File: rtl/lane_align.sv
// Narrows register data to the store size and places it on little-endian byte
// lanes across a two-word window; mask8 marks the lanes that carry the store.
module lane_align
  import store_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [63:0] wide,
  output logic [7:0]  mask8
);

  logic [31:0] masked;
  logic [7:0]  nmask;

  always_comb begin
    masked = '0;
    nmask  = '0;
    unique case (size)
      SZ_BYTE: begin masked = {24'b0, data[7:0]};  nmask = 8'h01; end
      SZ_HALF: begin masked = {16'b0, data[15:0]}; nmask = 8'h03; end
      SZ_WORD: begin masked = data;                nmask = 8'h0f; end
      default: begin masked = '0;                  nmask = 8'h00; end
    endcase
    wide  = {32'b0, masked} << {off, 3'b000};
    mask8 = nmask << off;
  end

endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store unit: captures both beats of a store at acceptance, then walks
// them out over a req/ack write bus while holding off the pipeline.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [LANES-1:0]  bus_be
);

  // Handshakes: a store transfers on st_valid & st_ready at a rising edge; a bus
  // beat transfers on bus_req & bus_ack at a rising edge, with all beat fields
  // held constant while bus_req is high. bus_ack without bus_req is ignored.

  state_t state, state_nxt;

  logic [63:0]       wide;
  logic [7:0]        mask8;
  logic [ADDR_W-1:0] b0_addr, b1_addr, st_word_addr;
  logic [DATA_W-1:0] b0_wdata, b1_wdata;
  logic [LANES-1:0]  b0_be, b1_be;
  logic              need_b1;
  logic              done_nxt, err_nxt, load;

  lane_align u_lane_align (
    .off   (st_addr[1:0]),
    .size  (st_size),
    .data  (st_data),
    .wide  (wide),
    .mask8 (mask8)
  );

  assign st_word_addr = {st_addr[ADDR_W-1:2], 2'b00};
  assign st_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign load         = st_valid && st_ready && (st_size != SZ_RSVD);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    bus_req   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    unique case (state)
      IDLE: begin
        if (st_valid) begin
          if (st_size == SZ_RSVD) err_nxt = 1'b1;
          else                    state_nxt = BEAT0;
        end
      end
      BEAT0: begin
        bus_req   = 1'b1;
        bus_addr  = b0_addr;
        bus_wdata = b0_wdata;
        bus_be    = b0_be;
        if (bus_ack) begin
          if (need_b1) begin
            state_nxt = BEAT1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      BEAT1: begin
        bus_req   = 1'b1;
        bus_addr  = b1_addr;
        bus_wdata = b1_wdata;
        bus_be    = b1_be;
        if (bus_ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // Second-beat address wraps modulo 2^ADDR_W, so the top word rolls to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_addr  <= '0;
      b1_addr  <= '0;
      b0_wdata <= '0;
      b1_wdata <= '0;
      b0_be    <= '0;
      b1_be    <= '0;
      need_b1  <= 1'b0;
    end else if (load) begin
      b0_addr  <= st_word_addr;
      b1_addr  <= st_word_addr + ADDR_W'(4);
      b0_wdata <= wide[31:0];
      b1_wdata <= wide[63:32];
      b0_be    <= mask8[3:0];
      b1_be    <= mask8[7:4];
      need_b1  <= |mask8[7:4];
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed plan cases plus random
// stores checked against a byte-by-byte reference model.
module tb_store_narrow_unit;

  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        busy, done, err;
  logic        bus_req, bus_ack;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  // Expected beats, packed as {addr[31:0], be[3:0], wdata[31:0]}
  logic [67:0] exp_q[$];

  store_narrow_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_req   (bus_req),
    .bus_ack   (bus_ack),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Walks the store one byte at a time: byte i goes to address addr+i, whose
  // word selects the beat and whose low bits select the lane.
  task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size);
    int          n, nb, lane;
    logic [31:0] a, w;
    logic [31:0] wa[2];
    logic [3:0]  be[2];
    logic [31:0] wd[2];
    n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      a    = addr + 32'(i);
      w    = {a[31:2], 2'b00};
      lane = int'(a[1:0]);
      if (nb == 0 || wa[nb-1] != w) begin
        wa[nb] = w;
        be[nb] = 4'b0;
        wd[nb] = 32'b0;
        nb++;
      end
      be[nb-1][lane]         = 1'b1;
      wd[nb-1][lane*8 +: 8]  = data[i*8 +: 8];
    end
    for (int b = 0; b < nb; b++) exp_q.push_back({wa[b], be[b], wd[b]});
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the unit idle; returns at the negedge of the done
  // cycle so the next store can be presented immediately.
  task automatic run_store(input string name, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size,
                           input int ack_delay);
    logic [67:0] e;
    int          nbeats;
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before: st_ready=%b want 1", name, st_ready);
    end
    st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    st_addr  = $urandom; st_data = $urandom; st_size = 2'($urandom_range(0, 3));
    nbeats = exp_q.size();
    for (int b = 0; b < nbeats; b++) begin
      e = exp_q.pop_front();
      for (int d = 0; d <= ack_delay; d++) begin
        total++;
        if (bus_req !== 1'b1 || busy !== 1'b1 || st_ready !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || bus_addr !== e[67:36] || bus_be !== e[35:32] ||
            bus_wdata !== e[31:0]) begin
          bad++;
          $display("FAIL %s beat%0d cyc%0d: req=%b busy=%b rdy=%b done=%b err=%b addr=%h be=%b wdata=%h want req=1 busy=1 rdy=0 done=0 err=0 addr=%h be=%b wdata=%h",
                   name, b, d, bus_req, busy, st_ready, done, err, bus_addr, bus_be,
                   bus_wdata, e[67:36], e[35:32], e[31:0]);
        end
        if (d == ack_delay) bus_ack = 1'b1;
        else                bus_ack = 1'($urandom_range(0, 1)) & 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0 || st_ready !== 1'b1 ||
        err !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b busy=%b req=%b rdy=%b err=%b want done=1 busy=0 req=0 rdy=1 err=0",
               name, done, busy, bus_req, st_ready, err);
    end
  endtask

  task automatic run_reserved(input string name, input logic [31:0] addr,
                              input logic [31:0] data);
    st_valid = 1'b1; st_addr = addr; st_data = data; st_size = 2'b11;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    total++;
    if (err !== 1'b1 || done !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0 ||
        st_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s err_pulse: err=%b done=%b req=%b busy=%b rdy=%b want err=1 done=0 req=0 busy=0 rdy=1",
               name, err, done, bus_req, busy, st_ready);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (err !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s err_after: err=%b req=%b busy=%b rdy=%b want err=0 req=0 busy=0 rdy=1",
               name, err, bus_req, busy, st_ready);
    end
  endtask

  task automatic idle_check(input string name);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: done=%b err=%b req=%b busy=%b want all 0",
               name, done, err, bus_req, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b addr=%h wdata=%h be=%b busy=%b done=%b err=%b want all 0",
               bus_req, bus_addr, bus_wdata, bus_be, busy, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: st_ready=%b busy=%b want 1 0", st_ready, busy);
    end
  endtask

  task automatic test_byte();
    exp_q.push_back({32'h0000_0010, 4'b1000, 32'hDD00_0000});
    run_store("byte", 32'h0000_0013, 32'hAABB_CCDD, 2'b00, 0);
    idle_check("byte");
  endtask

  task automatic test_word();
    exp_q.push_back({32'h0000_0100, 4'hF, 32'h1234_5678});
    run_store("word", 32'h0000_0100, 32'h1234_5678, 2'b10, 0);
    idle_check("word");
  endtask

  task automatic test_split_half();
    exp_q.push_back({32'h0000_0200, 4'b1000, 32'hEF00_0000});
    exp_q.push_back({32'h0000_0204, 4'b0001, 32'h0000_00BE});
    run_store("split_half", 32'h0000_0203, 32'h0000_BEEF, 2'b01, 0);
    idle_check("split_half");
  endtask

  task automatic test_wrap_word();
    exp_q.push_back({32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000});
    exp_q.push_back({32'h0000_0000, 4'b0011, 32'h0000_CAFE});
    run_store("wrap_word", 32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10, 3);
    idle_check("wrap_word");
  endtask

  task automatic test_reserved();
    run_reserved("reserved", 32'h0000_0040, 32'h1111_2222);
  endtask

  task automatic test_reset_mid();
    st_valid = 1'b1; st_addr = 32'h0000_0301; st_data = 32'h0000_0077; st_size = 2'b00;
    bus_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    total++;
    if (bus_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: req=%b busy=%b want 1 1", bus_req, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_async: req=%b busy=%b done=%b err=%b addr=%h be=%b wdata=%h want all 0",
               bus_req, busy, done, err, bus_addr, bus_be, bus_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'h0000_0300, 4'b0010, 32'h0000_7700});
    run_store("reset_mid_after", 32'h0000_0301, 32'h0000_0077, 2'b00, 1);
    idle_check("reset_mid_after");
  endtask

  task automatic test_back_to_back();
    model_store(32'h0000_1001, 32'h5566_7788, 2'b10);
    run_store("b2b_0", 32'h0000_1001, 32'h5566_7788, 2'b10, 0);
    model_store(32'h0000_2002, 32'h0000_ABCD, 2'b01);
    run_store("b2b_1", 32'h0000_2002, 32'h0000_ABCD, 2'b01, 0);
    run_reserved("b2b_2", 32'h0000_3000, 32'h0);
    model_store(32'h0000_4003, 32'h0000_1234, 2'b01);
    run_store("b2b_3", 32'h0000_4003, 32'h0000_1234, 2'b01, 2);
    idle_check("b2b");
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  s;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      if (i % 7 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      if (s == 2'b11) begin
        run_reserved("rand_rsvd", a, d);
      end else begin
        model_store(a, d, s);
        run_store("rand", a, d, s, $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) idle_check("rand");
      end
    end
    idle_check("rand_end");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte();
    test_word();
    test_split_half();
    test_wrap_word();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
